// File: rtl/sync_tx_arbiter_pkg.sv
// Shared definitions for the source-domain transmit arbiter:
// FSM state encodings, parameter defaults and width helpers.
package sync_tx_arbiter_pkg;

  // Parameter defaults used by sync_tx_arbiter.
  localparam int SYNC_BUS_WIDTH   = 8;
  localparam int SYNC_NUM_REQ     = 4;
  localparam int SYNC_HOLD_CYCLES = 4;
  localparam int SYNC_GAP_CYCLES  = 4;

  // Transfer FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } sync_state_e;

  // Width of a requester index; never below one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Counter wide enough to hold max(hold, gap) without wrapping.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above
// the pointer, wrapping modulo NUM_REQ. Returns one-hot and index.
module sync_rr_arbiter
  import sync_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = SYNC_NUM_REQ,
  parameter int IDX_W   = idx_width(SYNC_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    int pos;
    pos     = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_valid && i_req[pos]) begin
        o_valid    = 1'b1;
        o_gnt[pos] = 1'b1;
        o_idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/sync_tx_arbiter.sv
// Source-domain transmit arbiter: picks one requester round-robin, drives
// its word onto unsync_bus and qualifies it with bus_enable for HOLD_CYCLES,
// then keeps bus_enable low for GAP_CYCLES so the destination synchronizer
// always sees a clean low/high/low qualifier around a stable word.
module sync_tx_arbiter
  import sync_tx_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH   = SYNC_BUS_WIDTH,
  parameter int NUM_REQ     = SYNC_NUM_REQ,
  parameter int HOLD_CYCLES = SYNC_HOLD_CYCLES,
  parameter int GAP_CYCLES  = SYNC_GAP_CYCLES
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic                         busy
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  sync_state_e            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_ptr;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [BUS_WIDTH-1:0]   r_bus;
  logic                   r_en;

  logic [NUM_REQ-1:0]     w_win_oh;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_vld;
  logic [IDX_W-1:0]       w_ptr_nxt;
  logic [BUS_WIDTH-1:0]   w_word;
  logic [BUS_WIDTH-1:0]   w_words [NUM_REQ];

  // Split the flat request data into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign w_words[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
  end

  sync_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_win_oh),
    .o_idx   (w_win_idx),
    .o_valid (w_win_vld)
  );

  assign w_word    = w_words[w_win_idx];
  // Pointer moves past the winner so a re-raised request queues behind others.
  assign w_ptr_nxt = (w_win_idx == IDX_LAST) ? '0 : w_win_idx + 1'b1;

  // Transfer FSM with counter, round-robin pointer and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_bus   <= '0;
      r_en    <= 1'b0;
    end else begin
      // Grant is a single-cycle pulse; only an arbitration point re-raises it.
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_gnt   <= w_win_oh;
            r_bus   <= w_word;
            r_en    <= 1'b1;
            r_ptr   <= w_ptr_nxt;
          end
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
            r_en    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            // Last gap cycle doubles as an arbitration point for back-to-back.
            if (w_win_vld) begin
              r_state <= ST_HOLD;
              r_cnt   <= '0;
              r_gnt   <= w_win_oh;
              r_bus   <= w_word;
              r_en    <= 1'b1;
              r_ptr   <= w_ptr_nxt;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign unsync_bus = r_bus;
  assign bus_enable = r_en;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Directed bench for sync_tx_arbiter (NUM_REQ=4, BUS_WIDTH=8, HOLD=4, GAP=4).
module tb_sync_tx_arbiter;

  localparam int NR = 4;
  localparam int BW = 8;
  localparam logic [31:0] D0 = 32'hC3A55A3C; // req3=C3 req2=A5 req1=5A req0=3C
  localparam logic [31:0] K1 = 32'h11111111;
  localparam logic [31:0] K2 = 32'h22222222;
  localparam logic [31:0] K3 = 32'h33333333;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*BW-1:0] req_data = '0;
  logic [NR-1:0]   gnt;
  logic [BW-1:0]   unsync_bus;
  logic            bus_enable;
  logic            busy;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  bus;
    logic        en;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  sync_tx_arbiter #(
    .BUS_WIDTH   (BW),
    .NUM_REQ     (NR),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [7:0] eb,
                         input logic ee, input logic ebz);
    chk({tag, ".gnt"},  32'(gnt),        32'(eg));
    chk({tag, ".bus"},  32'(unsync_bus), 32'(eb));
    chk({tag, ".en"},   32'(bus_enable), 32'(ee));
    chk({tag, ".busy"}, 32'(busy),       32'(ebz));
  endtask

  task automatic add(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g,
                     input logic [7:0] b, input logic e, input logic bz);
    vec_t v;
    v.req = r; v.data = d; v.gnt = g; v.bus = b; v.en = e; v.busy = bz;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_order[5];
    int tmr[NR];
    int t, ng, last_t, run, maxrun, idx;
    logic [31:0] dw;

    // ---------------- reset with random requests ----------------
    req      = 4'($urandom_range(1, 15));
    req_data = $urandom;
    #1 RST = 1'b1;
    #1 chk_out("rst_async", 4'h0, 8'h00, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      req = 4'($urandom);
      req_data = $urandom;
      #1 chk_out("rst_held", 4'h0, 8'h00, 1'b0, 1'b0);
    end
    tick();
    req = '0;
    RST = 1'b0;

    // ---------------- table: single request, request in gap, drop before grant
    // row c: inputs driven during cycle c, outputs expected during cycle c
    add(4'b0100, D0, 4'b0000, 8'h00, 1'b0, 1'b0); // 0
    add(4'b0000, K1, 4'b0100, 8'hA5, 1'b1, 1'b1); // 1 grant req2
    add(4'b0000, K1, 4'b0000, 8'hA5, 1'b1, 1'b1); // 2
    add(4'b0000, K1, 4'b0000, 8'hA5, 1'b1, 1'b1); // 3
    add(4'b0000, K1, 4'b0000, 8'hA5, 1'b1, 1'b1); // 4
    for (int c = 5; c <= 8; c++) add(4'b0000, K1, 4'b0000, 8'hA5, 1'b0, 1'b1);
    add(4'b0000, K1, 4'b0000, 8'hA5, 1'b0, 1'b0); // 9 idle
    add(4'b0001, D0, 4'b0000, 8'hA5, 1'b0, 1'b0); // 10
    add(4'b0000, K2, 4'b0001, 8'h3C, 1'b1, 1'b1); // 11 grant req0
    add(4'b0000, K2, 4'b0000, 8'h3C, 1'b1, 1'b1); // 12
    add(4'b0010, K2, 4'b0000, 8'h3C, 1'b1, 1'b1); // 13 req1 rises
    add(4'b0010, K2, 4'b0000, 8'h3C, 1'b1, 1'b1); // 14
    for (int c = 15; c <= 17; c++) add(4'b0010, K2, 4'b0000, 8'h3C, 1'b0, 1'b1);
    add(4'b0010, D0, 4'b0000, 8'h3C, 1'b0, 1'b1); // 18 last gap
    add(4'b0000, K3, 4'b0010, 8'h5A, 1'b1, 1'b1); // 19 grant req1
    add(4'b0100, K3, 4'b0000, 8'h5A, 1'b1, 1'b1); // 20 req2 one-cycle pulse
    add(4'b0000, K3, 4'b0000, 8'h5A, 1'b1, 1'b1); // 21
    add(4'b0000, K3, 4'b0000, 8'h5A, 1'b1, 1'b1); // 22
    for (int c = 23; c <= 26; c++) add(4'b0000, K3, 4'b0000, 8'h5A, 1'b0, 1'b1);
    add(4'b0000, K3, 4'b0000, 8'h5A, 1'b0, 1'b0); // 27 idle, no gnt[2]
    add(4'b0000, K3, 4'b0000, 8'h5A, 1'b0, 1'b0); // 28

    foreach (tbl[i]) begin
      chk_out($sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].bus, tbl[i].en, tbl[i].busy);
      req      = tbl[i].req;
      req_data = tbl[i].data;
      tick();
    end

    // ---------------- reset in HOLD clears ptr (ptr would be 2 otherwise) ----
    req_data = D0;
    req = 4'b0010;
    tick();
    chk_out("rst_ptr.grant", 4'b0010, 8'h5A, 1'b1, 1'b1);
    req = 4'b0000;
    tick();                       // second HOLD cycle
    #3 RST = 1'b1;
    #1 chk_out("rst_ptr.mid", 4'h0, 8'h00, 1'b0, 1'b0);
    tick();
    req = 4'b0110;
    chk_out("rst_ptr.held", 4'h0, 8'h00, 1'b0, 1'b0);
    RST = 1'b0;
    tick();
    chk_out("rst_ptr.after", 4'b0010, 8'h5A, 1'b1, 1'b1);
    req = 4'b0000;
    repeat (8) tick();
    chk_out("rst_ptr.idle", 4'h0, 8'h5A, 1'b0, 1'b0);

    // ---------------- reset during HOLD of requester 3 ----------------
    req = 4'b1000;
    tick();
    chk_out("rst_hold.grant", 4'b1000, 8'hC3, 1'b1, 1'b1);
    req = 4'b0000;
    tick();                       // transfer cycle 2
    #3 RST = 1'b1;
    #1 chk_out("rst_hold.mid", 4'h0, 8'h00, 1'b0, 1'b0);
    #2 RST = 1'b0;
    req = 4'b1001;
    tick();
    chk_out("rst_hold.first", 4'b0001, 8'h3C, 1'b1, 1'b1);
    req = 4'b0000;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("rst_hold.nognt[%0d]", c), 32'(gnt), 32'h0);
    end
    tick();
    chk("rst_hold.idle", 32'(busy), 32'h0);

    // ---------------- all requesters, fairness and throughput ----------------
    RST = 1'b1;
    #2 RST = 1'b0;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) tmr[i] = 0;
    t = 0; ng = 0; last_t = -1; run = 0; maxrun = 0;
    dw = D0;
    req_data = D0;
    req = 4'b1111;
    while (ng < 5 && t < 60) begin
      tick();
      t++;
      if (bus_enable) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      for (int i = 0; i < NR; i++) begin
        if (tmr[i] > 0) begin
          tmr[i]--;
          if (tmr[i] == 0) req[i] = 1'b1;
        end
      end
      if (gnt != '0) begin
        idx = -1;
        for (int i = 0; i < NR; i++) if (gnt[i]) idx = i;
        chk($sformatf("rr.onehot[%0d]", ng), 32'($onehot(gnt)), 32'h1);
        chk($sformatf("rr.order[%0d]", ng), 32'(idx), 32'(exp_order[ng]));
        if (idx >= 0)
          chk($sformatf("rr.word[%0d]", ng), 32'(unsync_bus), 32'((dw >> (idx*8)) & 32'hFF));
        if (last_t >= 0)
          chk($sformatf("rr.spacing[%0d]", ng), 32'(t - last_t), 32'd8);
        last_t = t;
        if (idx >= 0) begin
          req[idx] = 1'b0;
          tmr[idx] = 2;
        end
        ng++;
      end
    end
    chk("rr.grant_count", 32'(ng), 32'd5);
    chk("rr.max_enable_run", 32'(maxrun), 32'd4);
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sync_tx_arbiter.md
SYNC_TX_ARBITER -- requirements
Module: sync_tx_arbiter

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, giving the width of each requester's data word and of unsync_bus.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles bus_enable stays high per transfer (minimum 1).
REQ-004 The block SHALL have parameter GAP_CYCLES, default 4, giving the minimum number of low bus_enable cycles between transfers (minimum 1).
REQ-005 The block SHALL have port CLK, input, 1 bit: the source-domain clock; the block uses one clock only.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req, input, NUM_REQ bits: per-requester transfer request, level, held until granted.
REQ-008 The block SHALL have port req_data, input, NUM_REQ*BUS_WIDTH bits: requester i's word occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-009 The block SHALL have port gnt, output, NUM_REQ bits: registered one-hot, one-cycle grant pulse.
REQ-010 The block SHALL have port unsync_bus, output, BUS_WIDTH bits: registered data word toward the destination-domain synchronizer.
REQ-011 The block SHALL have port bus_enable, output, 1 bit: registered qualifier toward the destination-domain synchronizer.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every cycle the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, HOLD and GAP.
REQ-014 An arbitration point SHALL be any cycle in IDLE, or the last GAP cycle (gap counter = GAP_CYCLES-1), in which req is non-zero.
REQ-015 At an arbitration point the block SHALL pick the winner round-robin: the first asserted req at or above index ptr, wrapping modulo NUM_REQ.
REQ-016 On the clock edge that ends an arbitration point, the block SHALL load unsync_bus with the winner's word, set gnt to the winner's one-hot bit for exactly one cycle, set bus_enable to 1, enter HOLD with the counter at 0, and set ptr to (winner+1) mod NUM_REQ.
REQ-017 In HOLD, bus_enable SHALL stay 1 for exactly HOLD_CYCLES cycles, after which the block SHALL enter GAP with bus_enable 0 and the counter cleared.
REQ-018 In GAP, bus_enable SHALL stay 0 for GAP_CYCLES cycles; at the last GAP cycle the block SHALL go to HOLD if req is non-zero, otherwise to IDLE.
REQ-019 unsync_bus SHALL change only on a grant edge and SHALL stay stable through the whole of HOLD and GAP, and in IDLE, until the next grant.
REQ-020 Back-to-back throughput SHALL be one transfer per HOLD_CYCLES+GAP_CYCLES cycles.
REQ-021 req SHALL be ignored outside arbitration points; a req dropped before its grant SHALL be discarded with no gnt issued.
REQ-022 A requester whose req is still high after its grant SHALL be treated as a new request and SHALL be eligible only after the other pending requesters (fairness).
REQ-023 The counter width SHALL be clog2(max(HOLD_CYCLES, GAP_CYCLES)+1), and the counter SHALL never wrap.
REQ-024 gnt SHALL be 0 in every cycle that does not immediately follow an arbitration point.

Reset
REQ-025 Asserting RST SHALL immediately force state=IDLE, ptr=0, counter=0, gnt=0, unsync_bus=0, bus_enable=0 and busy=0, independent of CLK.
REQ-026 A reset during HOLD or GAP SHALL abort the transfer with no further gnt, and the first grant after release SHALL follow REQ-015 with ptr=0.

Structure
REQ-027 The state encodings (IDLE=2'b00, HOLD=2'b01, GAP=2'b10) and the parameter defaults SHALL reside in the shared sync package/header.
REQ-028 The round-robin pick (req, ptr -> one-hot winner and index) SHALL be a combinational sub-module named sync_rr_arbiter.
REQ-029 The FSM, counter, ptr and output registers SHALL reside in sync_tx_arbiter.

Verification (NUM_REQ=4, BUS_WIDTH=8, HOLD=4, GAP=4)
REQ-030 Reset check: RST=1 with random req -> gnt=0, unsync_bus=0x00, bus_enable=0 and busy=0, including the case where RST asserts mid-cycle.
REQ-031 Single request: req=0100 and data[2]=0xA5 at cycle 0 -> gnt=0100 in cycle 1 only, unsync_bus=0xA5 from cycle 1, bus_enable high in cycles 1-4 and low in 5-8, busy high in 1-8, IDLE at cycle 9.
REQ-032 All requesters active: req=1111 held, each requester dropping its req after its grant and re-raising it 2 cycles later -> grant order 0,1,2,3,0, one grant every 8 cycles, and bus_enable never high for more than 4 consecutive cycles.
REQ-033 Request during GAP: req[1] rises in cycle 3 of a transfer granted in cycle 1 -> gnt=0010 in cycle 9, bus_enable low in cycles 5-8 and high in 9-12.
REQ-034 Reset during HOLD: RST pulses in cycle 2 of a transfer to requester 3 -> bus_enable=0 at once, and after release with req=1001 -> requester 0 granted first.
REQ-035 Drop before grant: req[2] pulses for 1 cycle during HOLD -> no gnt[2] is ever issued, and the block returns to IDLE after GAP.
